// File: rtl/addr_encoder_32to5.sv
// 32-to-5 address encoder: captures a request vector and emits each set index once, one per accepted cycle.
// Optional pending-count output enabled by defining ADDR_ENCODER_COUNT_EN.
module addr_encoder_32to5 #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enbl,
  input  logic        load,
  input  logic [31:0] req,
  input  logic        ready,
  output logic [4:0]  a,
  output logic        valid,
  output logic        busy,
  output logic        done
`ifdef ADDR_ENCODER_COUNT_EN
  ,
  output logic [5:0]  pcount
`endif
);

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  state_t      r_state;
  logic [31:0] r_pend;
  logic [4:0]  r_last;
  logic [4:0]  r_a;
  logic        r_valid;
  logic        r_done;

  state_t      w_state_nxt;
  logic [31:0] w_pend_nxt;
  logic [4:0]  w_last_nxt;
  logic [4:0]  w_a_nxt;
  logic        w_valid_nxt;
  logic        w_done_nxt;

  logic [31:0] w_rem;
  logic [4:0]  w_start_load;
  logic [4:0]  w_start_next;
  logic [4:0]  w_sel_load;
  logic [4:0]  w_sel_next;

  // Scanning downward lets the smallest offset from start win without a found flag.
  function automatic logic [4:0] f_pick(input logic [31:0] vec, input logic [4:0] start);
    logic [4:0] idx;
    f_pick = '0;
    for (int i = 31; i >= 0; i--) begin
      idx = start + 5'(i);
      if (vec[idx]) f_pick = idx;
    end
  endfunction

  assign w_rem        = r_pend & ~(32'b1 << r_a);
  assign w_start_load = (PRIO_MODE != 0) ? r_last + 5'd1 : 5'd0;
  assign w_start_next = (PRIO_MODE != 0) ? r_a + 5'd1    : 5'd0;
  assign w_sel_load   = f_pick(req, w_start_load);
  assign w_sel_next   = f_pick(w_rem, w_start_next);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_last_nxt  = r_last;
    w_a_nxt     = r_a;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enbl && load) begin
          if (req != '0) begin
            w_pend_nxt  = req;
            w_a_nxt     = w_sel_load;
            w_valid_nxt = 1'b1;
            w_state_nxt = EMIT;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (!enbl) begin
          w_pend_nxt  = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end else if (r_valid && ready) begin
          w_pend_nxt = w_rem;
          w_last_nxt = r_a;
          if (w_rem != '0) begin
            w_a_nxt = w_sel_next;
          end else begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all regs update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_last  <= 5'd31;
      r_a     <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_last  <= w_last_nxt;
      r_a     <= w_a_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign a     = r_a;
  assign valid = r_valid;
  assign done  = r_done;
  assign busy  = (r_state == EMIT);

`ifdef ADDR_ENCODER_COUNT_EN
  logic [5:0] r_pcount;

  function automatic logic [5:0] f_popcount(input logic [31:0] vec);
    f_popcount = '0;
    for (int i = 0; i < 32; i++) f_popcount = f_popcount + 6'(vec[i]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pcount <= '0;
    else     r_pcount <= f_popcount(w_pend_nxt);
  end

  assign pcount = r_pcount;
`endif

endmodule

// File: tb/tb_addr_encoder_32to5.sv
// Directed bench: one fixed-priority and one round-robin encoder share stimulus; vectors hold hand-computed results.
module tb_addr_encoder_32to5;

  logic        clk = 1'b0;
  logic        rst;
  logic        enbl;
  logic        load;
  logic [31:0] req;
  logic        ready;
  logic [4:0]  a0, a1;
  logic        valid0, valid1, busy0, busy1, done0, done1;
`ifdef ADDR_ENCODER_COUNT_EN
  logic [5:0]  pcount0, pcount1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  addr_encoder_32to5 #(.PRIO_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .enbl(enbl), .load(load), .req(req), .ready(ready),
    .a(a0), .valid(valid0), .busy(busy0), .done(done0)
`ifdef ADDR_ENCODER_COUNT_EN
    , .pcount(pcount0)
`endif
  );

  addr_encoder_32to5 #(.PRIO_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .enbl(enbl), .load(load), .req(req), .ready(ready),
    .a(a1), .valid(valid1), .busy(busy1), .done(done1)
`ifdef ADDR_ENCODER_COUNT_EN
    , .pcount(pcount1)
`endif
  );

  typedef struct {
    logic        load;
    logic        enbl;
    logic        ready;
    logic [31:0] req;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        valid;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [4:0] ea0, input logic [4:0] ea1,
                            input logic ev, input logic eb, input logic ed);
    check({tag, " a fixed"}, 32'(a0), 32'(ea0));
    check({tag, " a rr"},    32'(a1), 32'(ea1));
    check({tag, " valid fixed"}, 32'(valid0), 32'(ev));
    check({tag, " valid rr"},    32'(valid1), 32'(ev));
    check({tag, " busy fixed"},  32'(busy0),  32'(eb));
    check({tag, " busy rr"},     32'(busy1),  32'(eb));
    check({tag, " done fixed"},  32'(done0),  32'(ed));
    check({tag, " done rr"},     32'(done1),  32'(ed));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //                load  enbl  ready req            a0     a1     valid busy  done
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h8000_0011, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd4,  5'd4,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd31, 5'd31, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd31, 5'd31, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd31, 5'd31, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_0010, 5'd4,  5'd4,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd4,  5'd4,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h0000_0013, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd1,  5'd1,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd4,  5'd4,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd4,  5'd4,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h0000_0031, 5'd0,  5'd5,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd4,  5'd0,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd5,  5'd4,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd5,  5'd4,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h0,         5'd5,  5'd4,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd5,  5'd4,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_0006, 5'd1,  5'd1,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_00FF, 5'd1,  5'd1,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_00FF, 5'd1,  5'd1,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_00FF, 5'd1,  5'd1,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd2,  5'd2,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd2,  5'd2,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h0000_000F, 5'd2,  5'd2,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_0300, 5'd8,  5'd8,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0,         5'd8,  5'd8,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd8,  5'd8,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h0000_0300, 5'd8,  5'd8,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd9,  5'd9,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0,         5'd9,  5'd9,  1'b0, 1'b0, 1'b1});

    rst = 1'b1; enbl = 1'b0; load = 1'b0; req = '0; ready = 1'b0;
    repeat (3) step();
    check_both("reset", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef ADDR_ENCODER_COUNT_EN
    check("reset pcount", 32'(pcount0), 32'd0);
`endif
    rst = 1'b0; enbl = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      load = vecs[i].load; enbl = vecs[i].enbl; ready = vecs[i].ready; req = vecs[i].req;
      step();
      check_both($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1, vecs[i].valid, vecs[i].busy, vecs[i].done);
    end

    // Reset in the middle of EMIT with two bits pending.
    load = 1'b1; enbl = 1'b1; ready = 1'b0; req = 32'h0000_0300;
    step();
    check_both("pre-rst", 5'd8, 5'd8, 1'b1, 1'b1, 1'b0);
    load = 1'b0; req = '0;
    #2 rst = 1'b1;
    #1 check_both("async rst", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0; ready = 1'b1;
    step();
    check_both("post-rst idle1", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_both("post-rst idle2", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Single-bit request yields exactly one transfer.
    load = 1'b1; req = 32'h8000_0000;
    step();
    check_both("single load", 5'd31, 5'd31, 1'b1, 1'b1, 1'b0);
    load = 1'b0; req = '0;
    step();
    check_both("single accept", 5'd31, 5'd31, 1'b0, 1'b0, 1'b1);
    step();
    check_both("single after", 5'd31, 5'd31, 1'b0, 1'b0, 1'b0);

`ifdef ADDR_ENCODER_COUNT_EN
    load = 1'b1; req = 32'hFFFF_FFFF; ready = 1'b1;
    step();
    load = 1'b0; req = '0;
    for (int k = 0; k < 32; k++) begin
      check($sformatf("full a fixed k%0d", k), 32'(a0), 32'(k));
      check($sformatf("full a rr k%0d", k),    32'(a1), 32'(k));
      check($sformatf("pcount fixed k%0d", k), 32'(pcount0), 32'(32 - k));
      check($sformatf("pcount rr k%0d", k),    32'(pcount1), 32'(32 - k));
      step();
    end
    check("full pcount end", 32'(pcount0), 32'd0);
    check("full done end",   32'(done0),   32'd1);
    check("full valid end",  32'(valid1),  32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addr_encoder_32to5.md
ADDR_ENCODER_32TO5 -- requirements
Module: addr_encoder_32to5

Interface
REQ-001 SHALL have parameter: PRIO_MODE, 0, 0 = fixed priority (lowest index first), 1 = round-robin.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: enbl  input  1  block enable; 0 aborts and holds idle.
REQ-005 SHALL have port: load  input  1  capture req as a new pending set.
REQ-006 SHALL have port: req  input  32  request/wordline vector, bit i = address i.
REQ-007 SHALL have port: ready  input  1  consumer accepts a this cycle when valid=1.
REQ-008 SHALL have port: a  output  5  encoded address of the selected pending bit (registered).
REQ-009 SHALL have port: valid  output  1  a holds a pending address (registered).
REQ-010 SHALL have port: busy  output  1  high while in state EMIT.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after the last address is accepted or after an empty load.

Function
REQ-012 SHALL implement states IDLE and EMIT with a 32-bit pending register pend and a 5-bit last-served register last.
REQ-013 In IDLE, load=1 & enbl=1 & req!=0 SHALL set pend<=req, a<=selected index of req, valid<=1, and go to EMIT; valid is therefore high the cycle after load.
REQ-014 In IDLE, load=1 & enbl=1 & req==0 SHALL pulse done for one cycle, leave valid=0, and stay in IDLE.
REQ-015 load SHALL be ignored in EMIT, and in IDLE when enbl=0.
REQ-016 In EMIT, valid=1 & ready=0 SHALL hold a, valid, and pend unchanged.
REQ-017 In EMIT, valid=1 & ready=1 SHALL clear pend[a] and set last<=a; if other bits remain, a<=next selection in the same edge and valid stays 1, giving 1 address/cycle throughput.
REQ-018 In EMIT, acceptance of the final pending bit SHALL set valid<=0, pulse done, and go to IDLE.
REQ-019 PRIO_MODE=0 SHALL select the lowest set index.
REQ-020 PRIO_MODE=1 SHALL select the first set index searching upward from (last+1) mod 32, wrapping 31->0.
REQ-021 enbl=0 in EMIT SHALL clear pend and valid and return to IDLE at the next edge, with no done pulse; last is retained.
REQ-022 Each valid address SHALL be emitted exactly once per load; a single-bit req SHALL produce exactly one transfer.
REQ-023 a SHALL be held at its last value when valid=0; consumers ignore it.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, pend=0, a=0, valid=0, busy=0, done=0, and last=31 so that the first round-robin search starts at 0.
REQ-025 Reset asserted mid-EMIT SHALL discard all pending bits; after release, operation starts only on a new load.

Configuration
REQ-026 With macro ADDR_ENCODER_COUNT_EN defined, the block SHALL add output pcount (6 bits) equal to the popcount of pend, registered, reset 0, and updated in the same edge as pend.
REQ-027 Without ADDR_ENCODER_COUNT_EN, pcount SHALL be absent and there SHALL be no popcount logic.

Verification
REQ-028 PRIO_MODE=0, load req=32'h8000_0011, ready=1 -> a=0,4,31 on consecutive cycles with valid high, then done pulse, then valid=0.
REQ-029 PRIO_MODE=1, last=4 after a prior load, load req=32'h0000_0013 -> a order is 0,1,4 (search from index 5, wrapping).
REQ-030 load req=0 -> done pulses the next cycle, valid never rises, busy stays 0.
REQ-031 load req=32'h0000_0006, ready=0 for 3 cycles -> a=1 held stable with valid=1; ready=1 -> a=2, then done.
REQ-032 Mid-EMIT enbl=0 (or rst=1) with 2 bits pending -> valid=0 and IDLE next edge (immediately for rst), no done pulse; a later load behaves normally.
REQ-033 ADDR_ENCODER_COUNT_EN defined, load req=32'hFFFF_FFFF, ready=1 -> pcount goes 32,31,...,1,0 while a goes 0..31.
